conv_psum_quant: RTL and testbench

- Consumer end of the 9-tap conv adder tree. Takes the 20-bit signed tree output and its valid, and accumulates partial sums over `cfg_num_ch` input channels per output pixel.
- Per pixel, then adds bias, rounds, shifts, applies optional ReLU and saturates to int8.
- Results go into a small output FIFO drained by a valid/ready handshake toward the feature-map writer.
- The adder tree cannot stall, so the FIFO absorbs backpressure, and drops are flagged.

---
 rtl/conv_psum_quant.sv | 227 ++++++++++++++++++++++
 tb/tb_conv_psum_quant.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_psum_quant.sv
// conv_psum_quant: accumulates adder-tree sums over input channels per
// pixel, then adds bias, rounds, shifts, applies optional ReLU and
// saturates to int8 into a small output FIFO drained by valid/ready.
// Ports: clk, rstn (async active-low); cfg_* tile setup latched on
// cfg_start; acc_i/vld_i from the adder tree (never stalls);
// q_o/q_vld_o/q_rdy_i result stream; busy_o tile active; done_o pulse
// when the last pixel result reaches the FIFO; err_o sticky flags
// (bit0 result dropped on full FIFO, bit1 vld_i seen while idle).
module conv_psum_quant #(
    parameter int ACC_W      = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cfg_start,
    input  logic [7:0]  cfg_num_ch,
    input  logic [15:0] cfg_num_pix,
    input  logic [15:0] cfg_bias,
    input  logic [4:0]  cfg_shift,
    input  logic        cfg_relu,
    input  logic [19:0] acc_i,
    input  logic        vld_i,
    output logic [7:0]  q_o,
    output logic        q_vld_o,
    input  logic        q_rdy_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [1:0]  err_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic signed [ACC_W-1:0] QMAX = 127;
    localparam logic signed [ACC_W-1:0] QMIN = -128;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN
    } state_t;

    state_t state;

    // Latched tile configuration; counts held as (effective count - 1)
    logic [7:0]              ch_last;
    logic [15:0]             pix_last;
    logic signed [ACC_W-1:0] bias_q;
    logic [4:0]              shift_q;
    logic                    relu_q;

    logic [7:0]              ch_cnt;
    logic [15:0]             pix_cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_ext;
    logic signed [ACC_W-1:0] acc_sum;

    logic                    s1_vld;
    logic                    s1_last;
    logic signed [ACC_W-1:0] s1_sum;

    logic                    s2_vld;
    logic                    s2_last;
    logic signed [ACC_W-1:0] s2_b;

    logic signed [ACC_W-1:0] rnd;
    logic signed [ACC_W-1:0] shifted;
    logic signed [ACC_W-1:0] clipped;
    logic [7:0]              q8;

    logic [7:0]              mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W:0]          count;
    logic                    full;
    logic                    pop;
    logic                    accept;
    logic                    drop;

    assign acc_ext = {{(ACC_W-20){acc_i[19]}}, acc_i};
    assign acc_sum = acc + acc_ext;

    // Control FSM, channel/pixel counters, accumulator and stage S1
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            ch_last  <= '0;
            pix_last <= '0;
            bias_q   <= '0;
            shift_q  <= '0;
            relu_q   <= 1'b0;
            ch_cnt   <= '0;
            pix_cnt  <= '0;
            acc      <= '0;
            s1_vld   <= 1'b0;
            s1_last  <= 1'b0;
            s1_sum   <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            err_o    <= '0;
        end else begin
            s1_vld <= 1'b0;
            done_o <= 1'b0;
            if (drop) begin
                err_o[0] <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (cfg_start) begin
                        ch_last  <= (cfg_num_ch == '0) ?
                                    '0 : cfg_num_ch - 8'd1;
                        pix_last <= (cfg_num_pix == '0) ?
                                    '0 : cfg_num_pix - 16'd1;
                        bias_q   <= {{(ACC_W-16){cfg_bias[15]}},
                                     cfg_bias};
                        shift_q  <= cfg_shift;
                        relu_q   <= cfg_relu;
                        acc      <= '0;
                        ch_cnt   <= '0;
                        pix_cnt  <= '0;
                        err_o    <= '0;
                        busy_o   <= 1'b1;
                        state    <= ACCUM;
                    end else if (vld_i) begin
                        err_o[1] <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (vld_i) begin
                        if (ch_cnt == ch_last) begin
                            s1_vld  <= 1'b1;
                            s1_sum  <= acc_sum;
                            s1_last <= (pix_cnt == pix_last);
                            acc     <= '0;
                            ch_cnt  <= '0;
                            pix_cnt <= pix_cnt + 16'd1;
                            if (pix_cnt == pix_last) begin
                                state <= DRAIN;
                            end
                        end else begin
                            acc    <= acc_sum;
                            ch_cnt <= ch_cnt + 8'd1;
                        end
                    end
                end
                DRAIN: begin
                    // The last result is written (or dropped) this edge
                    if (s2_vld && s2_last) begin
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stage S2: bias add
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_vld  <= 1'b0;
            s2_last <= 1'b0;
            s2_b    <= '0;
        end else begin
            s2_vld  <= s1_vld;
            s2_last <= s1_vld && s1_last;
            if (s1_vld) begin
                s2_b <= s1_sum + bias_q;
            end
        end
    end

    // Stage S3: round half up, arithmetic shift, ReLU, int8 saturate
    always_comb begin
        rnd = '0;
        if (shift_q != 5'd0) begin
            rnd = ACC_W'(1) << (shift_q - 5'd1);
        end
        shifted = (s2_b + rnd) >>> shift_q;
        clipped = shifted;
        if (relu_q && shifted[ACC_W-1]) begin
            clipped = '0;
        end
        if (clipped > QMAX) begin
            q8 = 8'h7f;
        end else if (clipped < QMIN) begin
            q8 = 8'h80;
        end else begin
            q8 = clipped[7:0];
        end
    end

    // Output FIFO; a full FIFO still accepts when the head pops
    assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign q_vld_o = (count != '0);
    assign pop     = q_vld_o && q_rdy_i;
    assign accept  = s2_vld && (!full || pop);
    assign drop    = s2_vld && full && !pop;
    assign q_o     = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= q8;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_psum_quant.sv
// tb_conv_psum_quant: directed vectors with hand-computed int8 results
// for conv_psum_quant.
module tb_conv_psum_quant;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cfg_start;
    logic [7:0]  cfg_num_ch;
    logic [15:0] cfg_num_pix;
    logic [15:0] cfg_bias;
    logic [4:0]  cfg_shift;
    logic        cfg_relu;
    logic [19:0] acc_i;
    logic        vld_i;
    logic [7:0]  q_o;
    logic        q_vld_o;
    logic        q_rdy_i;
    logic        busy_o;
    logic        done_o;
    logic [1:0]  err_o;

    int checks = 0;
    int errors = 0;

    conv_psum_quant #(
        .ACC_W(32),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .cfg_start(cfg_start),
        .cfg_num_ch(cfg_num_ch),
        .cfg_num_pix(cfg_num_pix),
        .cfg_bias(cfg_bias),
        .cfg_shift(cfg_shift),
        .cfg_relu(cfg_relu),
        .acc_i(acc_i),
        .vld_i(vld_i),
        .q_o(q_o),
        .q_vld_o(q_vld_o),
        .q_rdy_i(q_rdy_i),
        .busy_o(busy_o),
        .done_o(done_o),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int n, input int p, input int bias,
                         input int sh, input int relu);
        cfg_num_ch  = 8'(n);
        cfg_num_pix = 16'(p);
        cfg_bias    = 16'(bias);
        cfg_shift   = 5'(sh);
        cfg_relu    = 1'(relu);
        cfg_start   = 1'b1;
        step();
        cfg_start   = 1'b0;
    endtask

    // Consecutive calls keep vld_i high back-to-back
    task automatic send(input int v);
        acc_i = 20'(v);
        vld_i = 1'b1;
        step();
        vld_i = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done_o && n < 20) begin
            step();
            n++;
        end
        check(tag, 32'(done_o), 32'd1);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check({tag, "_vld"}, 32'(q_vld_o), 32'd1);
        check(tag, 32'(q_o), 32'(exp));
        q_rdy_i = 1'b1;
        step();
        q_rdy_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn        = 1'b0;
        cfg_start   = 1'b0;
        cfg_num_ch  = '0;
        cfg_num_pix = '0;
        cfg_bias    = '0;
        cfg_shift   = '0;
        cfg_relu    = 1'b0;
        acc_i       = '0;
        vld_i       = 1'b0;
        q_rdy_i     = 1'b0;
        step();
        step();
        check("rst_q", 32'(q_o), 32'd0);
        check("rst_qvld", 32'(q_vld_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        rstn = 1'b1;
        step();

        // Pass-through with exact latency
        start(1, 1, 0, 0, 0);
        check("pt_busy", 32'(busy_o), 32'd1);
        send(100);
        check("pt_lat1", 32'(q_vld_o), 32'd0);
        step();
        check("pt_lat2", 32'(q_vld_o), 32'd0);
        step();
        check("pt_vld", 32'(q_vld_o), 32'd1);
        check("pt_q", 32'(q_o), 32'd100);
        check("pt_done", 32'(done_o), 32'd1);
        step();
        check("pt_done_end", 32'(done_o), 32'd0);
        check("pt_idle", 32'(busy_o), 32'd0);
        q_rdy_i = 1'b1;
        step();
        q_rdy_i = 1'b0;
        check("pt_empty", 32'(q_vld_o), 32'd0);

        // Multi-channel with bias and shift
        start(3, 1, 12, 5, 0);
        send(1000);
        send(2000);
        send(-500);
        wait_done("mc5_done");
        pop_check("mc5_q", 8'd79);
        start(3, 1, 12, 4, 0);
        send(1000);
        send(2000);
        send(-500);
        wait_done("mc4_done");
        pop_check("mc4_sat", 8'd127);

        // ReLU and negative saturation
        start(1, 1, 0, 0, 1);
        send(-300);
        wait_done("relu_done");
        pop_check("relu_q", 8'h00);
        start(1, 1, 0, 0, 0);
        send(-300);
        wait_done("nsat_done");
        pop_check("nsat_q", 8'h80);

        // Rounding, four pixels fill the FIFO exactly
        start(1, 4, 0, 4, 0);
        send(-24);
        send(-25);
        send(8);
        send(7);
        wait_done("rnd_done");
        check("rnd_err", 32'(err_o), 32'd0);
        pop_check("rnd_m24", 8'hff);
        pop_check("rnd_m25", 8'hfe);
        pop_check("rnd_8", 8'h01);
        pop_check("rnd_7", 8'h00);
        check("rnd_empty", 32'(q_vld_o), 32'd0);

        // Backpressure: 5 and 6 are dropped
        start(1, 6, 0, 0, 0);
        for (int v = 1; v <= 6; v++) begin
            send(v);
        end
        wait_done("bp_done");
        check("bp_err", 32'(err_o), 32'd1);
        for (int v = 1; v <= 4; v++) begin
            pop_check($sformatf("bp_q%0d", v), 8'(v));
        end
        check("bp_empty", 32'(q_vld_o), 32'd0);

        // Pop and write on the same edge while full
        start(1, 5, 0, 0, 0);
        check("pw_errclr", 32'(err_o), 32'd0);
        for (int v = 10; v <= 14; v++) begin
            send(v);
        end
        step();
        q_rdy_i = 1'b1;
        step();
        q_rdy_i = 1'b0;
        check("pw_done", 32'(done_o), 32'd1);
        check("pw_err", 32'(err_o), 32'd0);
        for (int v = 11; v <= 14; v++) begin
            pop_check($sformatf("pw_q%0d", v), 8'(v));
        end
        check("pw_empty", 32'(q_vld_o), 32'd0);

        // vld_i in IDLE, then reset mid-tile
        send(7);
        check("idle_err", 32'(err_o), 32'd2);
        check("idle_qvld", 32'(q_vld_o), 32'd0);
        start(3, 2, 0, 0, 0);
        send(5);
        send(6);
        rstn = 1'b0;
        #1;
        check("mrst_q", 32'(q_o), 32'd0);
        check("mrst_qvld", 32'(q_vld_o), 32'd0);
        check("mrst_busy", 32'(busy_o), 32'd0);
        check("mrst_done", 32'(done_o), 32'd0);
        check("mrst_err", 32'(err_o), 32'd0);
        rstn = 1'b1;
        step();
        start(3, 1, 0, 0, 0);
        send(5);
        send(6);
        send(7);
        wait_done("post_done");
        check("post_err", 32'(err_o), 32'd0);
        pop_check("post_q", 8'd18);
        check("post_empty", 32'(q_vld_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
